// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus controller and its request encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_dbus_ctrl_pkg;

  // Controller state encodings
  typedef enum logic [1:0] {
    DBUS_IDLE = 2'd0,
    DBUS_REQ  = 2'd1,
    DBUS_WAIT = 2'd2,
    DBUS_DONE = 2'd3
  } dbus_state_t;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Encoded request shape derived from the byte-lane select
  typedef struct packed {
    logic [1:0] size;
    logic [1:0] offset;
    logic [3:0] wstrb;
    logic       valid;
  } dbus_enc_t;

endpackage

// File: rtl/mem_dbus_ctrl_dbus_req_encode.sv
// Maps a byte-lane select to bus size, byte offset and write strobes.
// Latency: combinational.
// Backpressure: none; valid=0 flags a select pattern that must not be issued.
module dbus_req_encode
  import mem_dbus_ctrl_pkg::*;
(
  input  logic       we,
  input  logic [3:0] sel,
  output dbus_enc_t  enc
);

  // Reads are always full words; writes take their shape from the lane select
  always_comb begin
    enc.size   = SIZE_WORD;
    enc.offset = 2'd0;
    enc.wstrb  = 4'b0000;
    enc.valid  = 1'b1;
    if (we) begin
      enc.wstrb = sel;
      unique case (sel)
        4'b0001: begin enc.size = SIZE_BYTE; enc.offset = 2'd0; end
        4'b0010: begin enc.size = SIZE_BYTE; enc.offset = 2'd1; end
        4'b0100: begin enc.size = SIZE_BYTE; enc.offset = 2'd2; end
        4'b1000: begin enc.size = SIZE_BYTE; enc.offset = 2'd3; end
        4'b0011: begin enc.size = SIZE_HALF; enc.offset = 2'd0; end
        4'b1100: begin enc.size = SIZE_HALF; enc.offset = 2'd2; end
        4'b1111: begin enc.size = SIZE_WORD; enc.offset = 2'd0; end
        // 0000 is an unaligned access already raised as an exception;
        // other patterns are never produced by MEM and are not issued either
        default: enc.valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// Turns MEM's combinational RAM request into one single-outstanding req/addr_ok/data_ok bus transfer.
// Latency: min 3 cycles request->DONE (REQ, WAIT, DONE); stall_req_o covers the request cycle through WAIT.
// Backpressure: holds req and fields until addr_ok; holds DONE while stall_i; flush cancels data, never the bus transfer.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_en_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_wdata_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] ram_rdata_o,
  output logic              stall_req_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  dbus_state_t state;
  logic        cancel_r;
  dbus_enc_t   enc;
  logic        start;
  logic        cancel_now;

  dbus_req_encode u_enc (
    .we  (ram_we_i),
    .sel (ram_sel_i),
    .enc (enc)
  );

  assign start      = ram_en_i & ~flush_i & enc.valid;
  // A flush arriving in the same cycle as data_ok must discard that data too
  assign cancel_now = cancel_r | flush_i;

  // Stall the pipeline from the request cycle until the transfer has completed
  always_comb begin
    stall_req_o = reset & (((state == DBUS_IDLE) & start) |
                           (state == DBUS_REQ) | (state == DBUS_WAIT));
  end

  // Transfer sequencing, registered bus request fields and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= DBUS_IDLE;
      cancel_r     <= 1'b0;
      ram_rdata_o  <= '0;
      data_req_o   <= 1'b0;
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'd0;
      data_addr_o  <= '0;
      data_wstrb_o <= 4'b0000;
      data_wdata_o <= '0;
    end else begin
      unique case (state)
        DBUS_IDLE: begin
          if (start) begin
            state        <= DBUS_REQ;
            data_req_o   <= 1'b1;
            data_wr_o    <= ram_we_i;
            data_size_o  <= enc.size;
            // MEM addresses are word aligned, so OR-ing in the lane offset is an add
            data_addr_o  <= ram_addr_i | {{(ADDR_W-2){1'b0}}, enc.offset};
            data_wstrb_o <= enc.wstrb;
            data_wdata_o <= ram_wdata_i;
          end
        end
        DBUS_REQ: begin
          // The request is never withdrawn; a flush only marks the result as dead
          if (flush_i) cancel_r <= 1'b1;
          if (data_addr_ok_i) begin
            data_req_o <= 1'b0;
            state      <= DBUS_WAIT;
          end
        end
        DBUS_WAIT: begin
          if (flush_i) cancel_r <= 1'b1;
          if (data_data_ok_i) begin
            if (!data_wr_o && !cancel_now) ram_rdata_o <= data_rdata_i;
            if (cancel_now) begin
              cancel_r <= 1'b0;
              state    <= DBUS_IDLE;
            end else begin
              state <= DBUS_DONE;
            end
          end
        end
        DBUS_DONE: begin
          // The finished instruction is still on ram_en_i; stay here until it moves on
          if (flush_i || !stall_i) state <= DBUS_IDLE;
        end
        default: state <= DBUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_en_i, ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i, ram_wdata_i;
  logic        flush_i, stall_i;
  logic [31:0] ram_rdata_o;
  logic        stall_req_o;
  logic        data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;

  always #5 clk = ~clk;

  mem_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ram_en_i       (ram_en_i),
    .ram_we_i       (ram_we_i),
    .ram_sel_i      (ram_sel_i),
    .ram_addr_i     (ram_addr_i),
    .ram_wdata_i    (ram_wdata_i),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .ram_rdata_o    (ram_rdata_o),
    .stall_req_o    (stall_req_o),
    .data_req_o     (data_req_o),
    .data_wr_o      (data_wr_o),
    .data_size_o    (data_size_o),
    .data_addr_o    (data_addr_o),
    .data_wstrb_o   (data_wstrb_o),
    .data_wdata_o   (data_wdata_o),
    .data_addr_ok_i (data_addr_ok_i),
    .data_data_ok_i (data_data_ok_i),
    .data_rdata_i   (data_rdata_i)
  );

  // Bus request as the slave should see it (wdata only meaningful for writes)
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } breq_t;

  typedef struct {
    int          adly;
    int          ddly;
    logic [31:0] rdata;
  } resp_t;

  breq_t       req_q[$];
  resp_t       resp_q[$];
  logic [31:0] exp_rd_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rdata = 32'h0;
  bit          slave_hold = 1'b0;
  bit          mon_en = 1'b1;
  logic        mon_prev = 1'b0;

  logic [3:0]  legal_sel [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0011, 4'b1100, 4'b1111, 4'b0000};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: reads are words at the given address; writes are as wide as the
  // number of selected lanes and start at the lowest selected lane
  function automatic breq_t model_req(input bit we, input logic [3:0] sel,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    breq_t r;
    int    low;
    int    ones;
    low  = 0;
    ones = $countones(sel);
    for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
    r.wr = we;
    if (!we) begin
      r.size  = 2'd2;
      r.addr  = addr;
      r.wstrb = 4'b0000;
      r.wdata = 32'h0;
    end else begin
      r.size  = (ones == 1) ? 2'd0 : (ones == 2) ? 2'd1 : 2'd2;
      r.addr  = addr + 32'(low);
      r.wstrb = sel;
      r.wdata = wdata;
    end
    return r;
  endfunction

  function automatic breq_t bus_now();
    breq_t r;
    r.wr    = data_wr_o;
    r.size  = data_size_o;
    r.addr  = data_addr_o;
    r.wstrb = data_wstrb_o;
    r.wdata = data_wr_o ? data_wdata_o : 32'h0;
    return r;
  endfunction

  // Bus slave: answers each request with the queued delays and data, checks the fields
  initial begin : slave
    resp_t r;
    breq_t e;
    forever begin
      @(negedge clk);
      data_data_ok_i = 1'b0;
      if (slave_hold) continue;
      if (data_req_o) begin
        if (resp_q.size() == 0 || req_q.size() == 0) begin
          check("unexpected_req", 1'b1, 1'b0);
        end else begin
          r = resp_q.pop_front();
          e = req_q.pop_front();
          for (int k = 0; k < r.adly; k++) begin
            check("req_stable", bus_now(), e);
            check("req_held", data_req_o, 1'b1);
            @(negedge clk);
          end
          check("req_fields", bus_now(), e);
          data_addr_ok_i = 1'b1;
          @(negedge clk);
          data_addr_ok_i = 1'b0;
          check("req_dropped", data_req_o, 1'b0);
          for (int k = 0; k < r.ddly; k++) @(negedge clk);
          data_data_ok_i = 1'b1;
          data_rdata_i   = r.rdata;
          @(negedge clk);
          data_data_ok_i = 1'b0;
          data_rdata_i   = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray data_ok outside a transfer must be ignored
        data_data_ok_i = 1'b1;
        data_rdata_i   = $urandom;
      end
    end
  end

  // Monitor: each time the stall request falls the read data presented to MEM is checked
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && mon_prev && !stall_req_o) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          check("rdata_at_done", ram_rdata_o, exp_rd_q.pop_front());
          check("no_req_at_done", data_req_o, 1'b0);
        end
      end
      mon_prev = stall_req_o;
    end
  end

  // One MEM access; starts and ends on a falling edge.
  // fmode: 0 none, 1 flush while in REQ, 2 flush while in WAIT. hold: DONE stall cycles.
  task automatic issue(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int adly, input int ddly, input int fmode, input int hold);
    int stall_n;
    bit done;
    bit fl_done;
    ram_en_i    = 1'b1;
    ram_we_i    = we;
    ram_sel_i   = sel;
    ram_addr_i  = addr;
    ram_wdata_i = wdata;
    flush_i     = 1'b0;
    stall_i     = 1'b0;
    if (we && sel == 4'b0000) begin
      #1 check("no_start_stall", stall_req_o, 1'b0);
      @(negedge clk);
      check("no_start_req", data_req_o, 1'b0);
      ram_en_i = 1'b0;
      @(negedge clk);
      return;
    end
    req_q.push_back(model_req(we, sel, addr, wdata));
    resp_q.push_back('{adly, ddly, rdata});
    if (!we && fmode == 0) model_rdata = rdata;
    exp_rd_q.push_back(model_rdata);
    #1 check("start_stall", stall_req_o, 1'b1);
    stall_n = 1;
    done    = 1'b0;
    fl_done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      flush_i = 1'b0;
      if (!stall_req_o) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (!fl_done && ((fmode == 1 && data_req_o) || (fmode == 2 && !data_req_o))) begin
          flush_i  = 1'b1;
          ram_en_i = 1'b0;
          fl_done  = 1'b1;
        end
      end
    end
    if (!done) begin
      check("complete_timeout", 1'b0, 1'b1);
    end else if (fmode == 0) begin
      check("stall_cycles", stall_n, 3 + adly + ddly);
      for (int k = 0; k < hold; k++) begin
        stall_i = 1'b1;
        @(negedge clk);
        check("done_hold_stall", stall_req_o, 1'b0);
        check("done_no_reissue", data_req_o, 1'b0);
        check("done_hold_rdata", ram_rdata_o, model_rdata);
      end
    end
    stall_i  = 1'b0;
    ram_en_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin : stim
    int r;
    reset          = 1'b0;
    ram_en_i       = 1'b1;
    ram_we_i       = 1'b0;
    ram_sel_i      = 4'b0000;
    ram_addr_i     = 32'h0;
    ram_wdata_i    = 32'h0;
    flush_i        = 1'b0;
    stall_i        = 1'b0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stall_req", stall_req_o, 1'b0);
    check("rst_data_req", data_req_o, 1'b0);
    check("rst_data_wr", data_wr_o, 1'b0);
    check("rst_data_size", data_size_o, 2'd0);
    check("rst_data_addr", data_addr_o, 32'h0);
    check("rst_data_wstrb", data_wstrb_o, 4'h0);
    check("rst_data_wdata", data_wdata_o, 32'h0);
    check("rst_ram_rdata", ram_rdata_o, 32'h0);
    ram_en_i = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(1'b0, 4'b0000, 32'h8000_1000, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0);
    issue(1'b1, 4'b0100, 32'h0000_0040, 32'h5A5A_5A5A, 32'h0,         0, 0, 0, 0);
    issue(1'b1, 4'b1100, 32'h0000_1234 & ~32'h3, 32'hA5A5_0000, 32'h0, 3, 1, 0, 0);
    issue(1'b0, 4'b0000, 32'h0000_2000, 32'h0,         32'h1234_5678, 0, 2, 2, 0);
    issue(1'b0, 4'b0000, 32'h0000_2004, 32'h0,         32'hCAFE_F00D, 1, 0, 0, 2);
    issue(1'b1, 4'b0000, 32'h0000_3001, 32'h0,         32'h0,         0, 0, 0, 0);
    issue(1'b0, 4'b0000, 32'h0000_3008, 32'h0,         32'h0BAD_0BAD, 2, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit          we;
      logic [3:0]  sel;
      int          fm;
      we  = 1'($urandom_range(0, 1));
      sel = legal_sel[$urandom_range(0, 7)];
      r   = $urandom_range(0, 5);
      fm  = (r < 4) ? 0 : (r == 4) ? 1 : 2;
      issue(we, we ? sel : 4'b0000, $urandom & ~32'h3, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), fm, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset while a request is on the bus
    slave_hold  = 1'b1;
    mon_en      = 1'b0;
    ram_en_i    = 1'b1;
    ram_we_i    = 1'b0;
    ram_sel_i   = 4'b0000;
    ram_addr_i  = 32'h8000_0100;
    @(negedge clk);
    check("rstmid_in_req", data_req_o, 1'b1);
    reset = 1'b0;
    #1;
    check("rstmid_data_req", data_req_o, 1'b0);
    check("rstmid_stall_req", stall_req_o, 1'b0);
    check("rstmid_data_addr", data_addr_o, 32'h0);
    check("rstmid_data_size", data_size_o, 2'd0);
    check("rstmid_ram_rdata", ram_rdata_o, 32'h0);
    ram_en_i = 1'b0;
    @(negedge clk);
    reset       = 1'b1;
    model_rdata = 32'h0;
    @(negedge clk);
    check("rstmid_idle_req", data_req_o, 1'b0);
    check("rstmid_idle_stall", stall_req_o, 1'b0);
    slave_hold = 1'b0;
    mon_en     = 1'b1;
    @(negedge clk);
    issue(1'b0, 4'b0000, 32'h8000_0100, 32'h0, 32'h7777_1111, 1, 1, 0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_rd_q.size() + req_q.size() + resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dbus_ctrl.md
Name: mem_dbus_ctrl

Overview:
- Sequential data-bus controller directly downstream of the MEM stage.
- Consumes MEM's combinational RAM request (ram_en/ram_we/ram_sel/ram_addr/ram_wdata) and drives a single-outstanding SRAM-like data bus (req/addr_ok/data_ok).
- Returns read data to MEM as ram_rdata, and raises a stall request to the pipeline controller while a transaction is in flight.
- Handles exception flush of an in-flight access.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus data width (fixed 32 for this core)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ram_en_i  in  1  MEM access enable
- ram_we_i  in  1  MEM write enable (already exception-masked)
- ram_sel_i  in  4  MEM byte-lane select (writes only)
- ram_addr_i  in  ADDR_W  word-aligned address from MEM
- ram_wdata_i  in  DATA_W  lane-replicated write data
- flush_i  in  1  exception flush of the MEM instruction
- stall_i  in  1  pipeline held by a later stage or the controller
- ram_rdata_o  out  DATA_W  read data to MEM
- stall_req_o  out  1  stall request to the controller
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = write
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_addr_o  out  ADDR_W  byte address
- data_wstrb_o  out  4  write strobes
- data_wdata_o  out  DATA_W  write data
- data_addr_ok_i  in  1  address accepted
- data_data_ok_i  in  1  write done or read data valid
- data_rdata_i  in  DATA_W  read data

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low.
- Reset values: state = IDLE; all data_* outputs = 0; ram_rdata_o = 0; stall_req_o = 0; cancel_r = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - start = ram_en_i & ~flush_i.
  - On start: latch the request fields, go to REQ.
  - stall_req_o = start (combinational), so the pipeline holds in the same cycle.
- REQ:
  - data_req_o = 1; all request fields are registered and held stable until data_addr_ok_i.
  - On addr_ok, go to WAIT.
  - req is never withdrawn, even on flush.
- WAIT:
  - data_data_ok_i is honoured only in this state.
  - On data_ok: capture data_rdata_i into ram_rdata_o (reads only; writes leave it unchanged).
  - Next state: IDLE if cancel_r, else DONE.
- DONE:
  - stall_req_o = 0 and ram_rdata_o is held, so MEM/WB sample the data.
  - Stay while stall_i = 1; go to IDLE when stall_i = 0.
  - DONE prevents re-issuing the same instruction, which is still present on ram_en_i.
- stall_req_o = 1 in REQ and in WAIT. Flush priority over stall is the controller's job.
- Flush handling:
  - flush_i in REQ or WAIT sets cancel_r. The transaction completes on the bus; read data is discarded; FSM returns to IDLE without DONE. cancel_r clears on exit.
  - flush_i in DONE: go to IDLE.
  - flush_i in IDLE: no start.
- Request encoding:
  - Read: size = 2, addr = ram_addr_i, wstrb = 0.
  - Write, wstrb = ram_sel_i. Size and address offset by sel:
    - 0001: size 0, offset +0
    - 0010: size 0, offset +1
    - 0100: size 0, offset +2
    - 1000: size 0, offset +3
    - 0011: size 1, offset +0
    - 1100: size 1, offset +2
    - 1111: size 2, offset +0
  - Write with ram_sel_i = 0000 (unaligned, already raised as an exception): no start.
- Minimum latency, addr_ok and data_ok on first opportunity: request cycle t, REQ t+1, WAIT t+2, DONE t+3. The stall covers t..t+2.
- Exactly one outstanding transaction.
- Reset mid-transaction returns to IDLE immediately; the bus side is reset concurrently.

Decomposition:
- Shared defines header gains:
  - state encodings DBUS_IDLE/REQ/WAIT/DONE
  - size codes SIZE_BYTE/HALF/WORD
- One sub-module, dbus_req_encode: combinational sel → {size, byte offset, wstrb}, reusable by the instruction-side bridge.

Test Plan:
- Word read at 0x8000_1000, addr_ok at t+1, data_ok at t+2 with 0xDEAD_BEEF → stall_req_o high t..t+2; ram_rdata_o = 0xDEAD_BEEF in DONE; no second req.
- Byte write sel = 0100, addr 0x0000_0040, wdata 0x5A5A_5A5A → data_addr_o = 0x42, size 0, wstrb 0100, data_wr_o = 1.
- addr_ok delayed 3 cycles → req and all fields stable across the delay; stall_req_o held throughout.
- flush_i pulsed in WAIT, then data_ok with 0x1234_5678 → FSM returns to IDLE, skips DONE, ram_rdata_o unchanged; next access issues normally.
- stall_i = 1 for 2 cycles in DONE → stays in DONE with data held; no re-issue; IDLE after stall_i falls.
- reset asserted in REQ → all outputs 0 asynchronously; IDLE after release.
